// File: rtl/axi_cfg_initiator.sv
// Single-outstanding AXI4 initiator: turns command-port requests into single-beat
// 32-bit AXI writes/reads and hands the response back to the requester.

package axi_cfg_pkg;

    typedef struct packed {
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic [3:0]  awqos;
        logic [3:0]  awregion;
        logic        awuser;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wuser;
        logic        wvalid;
        logic        bready;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arlock;
        logic [3:0]  arcache;
        logic [2:0]  arprot;
        logic [3:0]  arqos;
        logic [3:0]  arregion;
        logic        aruser;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
    } s_axi_miso_t;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

endpackage

module axi_cfg_initiator
    import axi_cfg_pkg::*;
#(
    parameter logic [3:0] AXI_ID   = '0,
    parameter bit         CHECK_ID = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output s_axi_mosi_t axi_mosi,
    input  s_axi_miso_t axi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        aw_done;
    logic        w_done;
    logic        bready_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        first_beat;

    logic        aw_hs;
    logic        w_hs;
    logic        bid_bad;
    logic        rid_bad;
    logic        unused_addr_lsb;

    assign aw_hs           = awvalid_q & axi_miso.awready;
    assign w_hs            = wvalid_q & axi_miso.wready;
    assign bid_bad         = CHECK_ID && (axi_miso.bid != AXI_ID);
    assign rid_bad         = CHECK_ID && (axi_miso.rid != AXI_ID);
    assign unused_addr_lsb = ^cmd_addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            first_beat <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= {cmd_addr[31:2], 2'b00};
                        wdata_q   <= cmd_wdata;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                // AW and W complete independently; either may finish first.
                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi_miso.bvalid && bready_q) begin
                        bready_q  <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= (axi_miso.bresp != AXI_RESP_OKAY) || bid_bad;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (axi_miso.arready) begin
                        arvalid_q  <= 1'b0;
                        rready_q   <= 1'b1;
                        first_beat <= 1'b1;
                        state      <= RD_RESP;
                    end
                end
                // Only the first beat carries the result; a missing rlast there
                // is an error and any trailing beats are drained and dropped.
                RD_RESP: begin
                    if (axi_miso.rvalid && rready_q) begin
                        first_beat <= 1'b0;
                        if (first_beat) begin
                            rsp_rdata <= axi_miso.rdata;
                            rsp_err   <= (axi_miso.rresp != AXI_RESP_OKAY) || rid_bad
                                         || !axi_miso.rlast;
                        end
                        if (axi_miso.rlast) begin
                            rready_q  <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        axi_mosi         = '0;
        axi_mosi.awid    = AXI_ID;
        axi_mosi.awaddr  = addr_q;
        axi_mosi.awsize  = AXI_SIZE_4B;
        axi_mosi.awburst = AXI_BURST_INCR;
        axi_mosi.awvalid = awvalid_q;
        axi_mosi.wdata   = wdata_q;
        axi_mosi.wstrb   = 4'hF;
        axi_mosi.wlast   = 1'b1;
        axi_mosi.wvalid  = wvalid_q;
        axi_mosi.bready  = bready_q;
        axi_mosi.arid    = AXI_ID;
        axi_mosi.araddr  = addr_q;
        axi_mosi.arsize  = AXI_SIZE_4B;
        axi_mosi.arburst = AXI_BURST_INCR;
        axi_mosi.arvalid = arvalid_q;
        axi_mosi.rready  = rready_q;
    end

endmodule

// File: tb/tb_axi_cfg_initiator.sv
// Bench for axi_cfg_initiator: configurable AXI responder, transaction-level model
// checked every cycle, and directed commands with hand-computed results.

module tb_axi_cfg_initiator;
    import axi_cfg_pkg::*;

    localparam logic [3:0] TB_ID    = 4'h5;
    localparam bit         TB_CHECK = 1'b1;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;

    int checks = 0;
    int failures = 0;

    axi_cfg_initiator #(.AXI_ID(TB_ID), .CHECK_ID(TB_CHECK)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .axi_mosi  (mosi),
        .axi_miso  (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    // ---------------- responder ----------------
    int          cfg_aw_lat = 0;
    int          cfg_w_lat = 0;
    int          cfg_rbeats = 1;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [3:0]  cfg_bid = TB_ID;
    logic [3:0]  cfg_rid = TB_ID;

    int          aw_age;
    int          w_age;
    logic        aw_got;
    logic        w_got;
    logic        bvalid_r;
    logic        rvalid_r;
    int          r_beat;
    logic [31:0] rdata_r;
    logic [31:0] lat_awaddr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [16];

    always_comb begin
        miso         = '0;
        miso.awready = mosi.awvalid && !aw_got && (aw_age >= cfg_aw_lat);
        miso.wready  = mosi.wvalid && !w_got && (w_age >= cfg_w_lat);
        miso.bvalid  = bvalid_r;
        miso.bid     = cfg_bid;
        miso.bresp   = cfg_bresp;
        miso.arready = mosi.arvalid && !rvalid_r;
        miso.rvalid  = rvalid_r;
        miso.rdata   = rdata_r;
        miso.rid     = cfg_rid;
        miso.rresp   = cfg_rresp;
        miso.rlast   = rvalid_r && (r_beat == cfg_rbeats - 1);
    end

    always @(posedge clk) begin
        if (!rst) begin
            aw_age   <= 0;
            w_age    <= 0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bvalid_r <= 1'b0;
            rvalid_r <= 1'b0;
            r_beat   <= 0;
            rdata_r  <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (mosi.awvalid && !aw_got) aw_age <= aw_age + 1;
            if (mosi.wvalid && !w_got) w_age <= w_age + 1;
            if (mosi.awvalid && miso.awready) begin
                aw_got     <= 1'b1;
                lat_awaddr <= mosi.awaddr;
            end
            if (mosi.wvalid && miso.wready) begin
                w_got     <= 1'b1;
                lat_wdata <= mosi.wdata;
            end
            if (!bvalid_r && (aw_got || (mosi.awvalid && miso.awready))
                          && (w_got || (mosi.wvalid && miso.wready)))
                bvalid_r <= 1'b1;
            if (bvalid_r && mosi.bready) begin
                bvalid_r <= 1'b0;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                aw_age   <= 0;
                w_age    <= 0;
                mem[lat_awaddr[5:2]] <= lat_wdata;
            end
            if (mosi.arvalid && miso.arready) begin
                rvalid_r <= 1'b1;
                r_beat   <= 0;
                rdata_r  <= mem[mosi.araddr[5:2]];
            end
            if (rvalid_r && mosi.rready) begin
                if (r_beat == cfg_rbeats - 1) rvalid_r <= 1'b0;
                else begin
                    r_beat  <= r_beat + 1;
                    rdata_r <= 32'hDEAD_BEEF;
                end
            end
        end
    end

    // ---------------- transaction model and per-cycle compare ----------------
    int          cyc, acc_cyc;
    logic        outst, is_wr, rsp_known, first_r;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_err;
    int          aw_n, w_n, ar_n, aw_vc, w_vc;
    int          last_aw_vc, last_w_vc, last_aw_n, last_w_n;
    logic [31:0] last_awaddr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        p_aw_wait, p_w_wait, p_ar_wait, p_rsp_wait;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
    logic        p_err;

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                outst = 1'b0; rsp_known = 1'b0; first_r = 1'b0;
                aw_n = 0; w_n = 0; ar_n = 0; aw_vc = 0; w_vc = 0;
                p_aw_wait = 1'b0; p_w_wait = 1'b0; p_ar_wait = 1'b0; p_rsp_wait = 1'b0;
            end else begin
                cyc++;
                if (outst) chk("cmd_ready_busy", cmd_ready, 0);
                else chk("idle_quiet", {mosi.awvalid, mosi.wvalid, mosi.arvalid,
                                        mosi.bready, mosi.rready, rsp_valid}, 0);
                if (p_aw_wait) begin
                    chk("aw_hold", mosi.awvalid, 1);
                    chk("aw_addr_stable", mosi.awaddr, p_awaddr);
                end
                if (p_w_wait) begin
                    chk("w_hold", mosi.wvalid, 1);
                    chk("w_data_stable", mosi.wdata, p_wdata);
                end
                if (p_ar_wait) begin
                    chk("ar_hold", mosi.arvalid, 1);
                    chk("ar_addr_stable", mosi.araddr, p_araddr);
                end
                if (p_rsp_wait) begin
                    chk("rsp_hold", rsp_valid, 1);
                    chk("rsp_rdata_stable", rsp_rdata, p_rdata);
                    chk("rsp_err_stable", rsp_err, p_err);
                end
                if (aw_n > 0) chk("aw_dropped", mosi.awvalid, 0);
                if (w_n > 0) chk("w_dropped", mosi.wvalid, 0);
                if (ar_n > 0) chk("ar_dropped", mosi.arvalid, 0);
                if (mosi.awvalid) aw_vc++;
                if (mosi.wvalid) w_vc++;

                if (mosi.awvalid && miso.awready) begin
                    chk("aw_is_write", is_wr, 1);
                    chk("awaddr", mosi.awaddr, e_addr);
                    chk("awid", mosi.awid, TB_ID);
                    chk("aw_fixed", {mosi.awlen, mosi.awsize, mosi.awburst}, {8'd0, 3'b010, 2'b01});
                    chk("aw_zero", {mosi.awlock, mosi.awcache, mosi.awprot, mosi.awqos,
                                    mosi.awregion, mosi.awuser}, 0);
                    last_awaddr = mosi.awaddr;
                    aw_n++;
                end
                if (mosi.wvalid && miso.wready) begin
                    chk("wdata", mosi.wdata, e_wdata);
                    chk("wstrb_wlast", {mosi.wstrb, mosi.wlast, mosi.wuser}, 6'b111110);
                    last_wdata = mosi.wdata;
                    last_wstrb = mosi.wstrb;
                    w_n++;
                end
                if (miso.bvalid && mosi.bready) begin
                    chk("aw_once", aw_n, 1);
                    chk("w_once", w_n, 1);
                    e_rdata = '0;
                    e_err = (miso.bresp != 2'b00) || (TB_CHECK && miso.bid != TB_ID);
                    rsp_known = 1'b1;
                    last_aw_vc = aw_vc; last_w_vc = w_vc; last_aw_n = aw_n; last_w_n = w_n;
                end
                if (mosi.arvalid && miso.arready) begin
                    chk("ar_is_read", is_wr, 0);
                    chk("araddr", mosi.araddr, e_addr);
                    chk("arid", mosi.arid, TB_ID);
                    chk("ar_fixed", {mosi.arlen, mosi.arsize, mosi.arburst}, {8'd0, 3'b010, 2'b01});
                    ar_n++;
                end
                if (miso.rvalid && mosi.rready) begin
                    if (first_r) begin
                        e_rdata = miso.rdata;
                        e_err = (miso.rresp != 2'b00) || (TB_CHECK && miso.rid != TB_ID) || !miso.rlast;
                        first_r = 1'b0;
                    end
                    if (miso.rlast) rsp_known = 1'b1;
                end
                if (rsp_valid) begin
                    chk("rsp_allowed", rsp_known, 1);
                    chk("rsp_min_latency", (cyc - acc_cyc) >= 3, 1);
                    chk("rsp_rdata", rsp_rdata, e_rdata);
                    chk("rsp_err", rsp_err, e_err);
                end
                if (rsp_valid && rsp_ready) begin
                    outst = 1'b0;
                    rsp_known = 1'b0;
                end
                if (cmd_valid && cmd_ready) begin
                    outst = 1'b1; is_wr = cmd_write; acc_cyc = cyc; first_r = 1'b1;
                    e_addr = {cmd_addr[31:2], 2'b00}; e_wdata = cmd_wdata;
                    aw_n = 0; w_n = 0; ar_n = 0; aw_vc = 0; w_vc = 0;
                end
                p_aw_wait = mosi.awvalid && !miso.awready; p_awaddr = mosi.awaddr;
                p_w_wait  = mosi.wvalid && !miso.wready;   p_wdata  = mosi.wdata;
                p_ar_wait = mosi.arvalid && !miso.arready; p_araddr = mosi.araddr;
                p_rsp_wait = rsp_valid && !rsp_ready; p_rdata = rsp_rdata; p_err = rsp_err;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int hold, output logic [31:0] rd, output logic er,
                           output int lat);
        int n;
        rd = '0; er = 1'b0; lat = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        rsp_ready = (hold == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
        if (!cmd_ready) begin
            timeout("cmd_accept");
            @(posedge clk); #1 cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = ~d;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 100);
        if (!rsp_valid) begin
            timeout("rsp_wait");
            rsp_ready = 1'b1;
            return;
        end
        rd = rsp_rdata; er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
        end
        if (hold > 0) begin @(posedge clk); #1 rsp_ready = 1'b1; end
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_axi_valids", {mosi.awvalid, mosi.wvalid, mosi.arvalid, mosi.bready, mosi.rready}, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        @(posedge clk); #1 rst = 1'b1;

        // write 0x8000_0000 to 0x0, always-ready responder
        run_cmd(1'b1, 32'h0, 32'h8000_0000, 0, rd, er, lat);
        chk("t1_latency", lat, 3);
        chk("t1_err", er, 0);
        chk("t1_rdata", rd, 0);
        chk("t1_awaddr", last_awaddr, 32'h0);
        chk("t1_wdata", last_wdata, 32'h8000_0000);
        chk("t1_wstrb", last_wstrb, 4'hF);

        // read-back
        run_cmd(1'b0, 32'h0, 32'h0, 0, rd, er, lat);
        chk("t3_rdata", rd, 32'h8000_0000);
        chk("t3_err", er, 0);
        chk("t3_latency", lat, 3);

        // wready one cycle after AW
        cfg_w_lat = 1;
        run_cmd(1'b1, 32'h0, 32'h1234_5678, 0, rd, er, lat);
        chk("t2_aw_cycles", last_aw_vc, 1);
        chk("t2_w_cycles", last_w_vc, 2);
        chk("t2_aw_hs", last_aw_n, 1);
        chk("t2_w_hs", last_w_n, 1);
        chk("t2_err", er, 0);

        // W completes before AW; unaligned address
        cfg_w_lat = 0; cfg_aw_lat = 2;
        run_cmd(1'b1, 32'h13, 32'hA5A5_0F0F, 0, rd, er, lat);
        chk("wfirst_aw_cycles", last_aw_vc, 3);
        chk("wfirst_w_cycles", last_w_vc, 1);
        chk("wfirst_awaddr", last_awaddr, 32'h10);
        cfg_aw_lat = 0;
        run_cmd(1'b0, 32'h12, 32'h0, 0, rd, er, lat);
        chk("wfirst_readback", rd, 32'hA5A5_0F0F);

        // SLVERR write, ID-mismatched read, then clean
        cfg_bresp = 2'b10;
        run_cmd(1'b1, 32'h4, 32'h1, 0, rd, er, lat);
        chk("t4_slverr", er, 1);
        cfg_bresp = 2'b00; cfg_rid = TB_ID + 4'd1;
        run_cmd(1'b0, 32'h0, 32'h0, 0, rd, er, lat);
        chk("t4_rid_err", er, 1);
        chk("t4_rid_rdata", rd, 32'h1234_5678);
        cfg_rid = TB_ID;
        run_cmd(1'b1, 32'h4, 32'h2, 0, rd, er, lat);
        chk("t4_clean_err", er, 0);

        // response backpressure, then missing rlast on first beat
        run_cmd(1'b0, 32'h0, 32'h0, 10, rd, er, lat);
        chk("t5_bp_rdata", rd, 32'h1234_5678);
        chk("t5_bp_err", er, 0);
        cfg_rbeats = 2;
        run_cmd(1'b0, 32'h0, 32'h0, 0, rd, er, lat);
        chk("t5_rlast_err", er, 1);
        chk("t5_rlast_rdata", rd, 32'h1234_5678);
        cfg_rbeats = 1;

        // reset during WR_REQ with awvalid held
        cfg_aw_lat = 50;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'h5555_AAAA;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
            if (!cmd_ready) timeout("t6_accept");
            @(posedge clk); #1 cmd_valid = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!mosi.awvalid && n < 10);
            chk("t6_awvalid_before_rst", mosi.awvalid, 1);
            @(posedge clk); #1 rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("t6_valids_cleared", {mosi.awvalid, mosi.wvalid, mosi.arvalid,
                                      mosi.bready, mosi.rready, rsp_valid}, 0);
            chk("t6_cmd_ready_in_rst", cmd_ready, 0);
            @(posedge clk); #1 rst = 1'b1;
            cfg_aw_lat = 0;
            n = 0;
            do begin @(negedge clk); n++; end while (!cmd_ready && n < 10);
            chk("t6_cmd_ready_after", cmd_ready, 1);
        end
        run_cmd(1'b1, 32'h8, 32'h5555_AAAA, 0, rd, er, lat);
        chk("t6_write_err", er, 0);
        chk("t6_write_latency", lat, 3);
        run_cmd(1'b0, 32'h8, 32'h0, 0, rd, er, lat);
        chk("t6_readback", rd, 32'h5555_AAAA);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
